// File: rtl/mem_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_ctrl_pkg
// Description : Shared definitions for the memory access sequencer: opcode
//               encodings, bus direction constants, FSM state encoding and
//               the wait-counter width.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_ctrl_pkg;

    // Data access opcodes; any other value on op_code is illegal
    localparam logic [3:0] OP_LDR = 4'b1101;
    localparam logic [3:0] OP_STR = 4'b1110;

    // Bus direction as driven on RW
    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

    // Wide enough for the largest supported TIMEOUT_CYC (31)
    localparam int CNT_W = 5;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        FETCH_WAIT = 2'd1,
        LOAD_WAIT  = 2'd2,
        STORE_WAIT = 2'd3
    } state_t;

    function automatic logic is_legal_op(input logic [3:0] op);
        return (op == OP_LDR) || (op == OP_STR);
    endfunction

endpackage : mem_ctrl_pkg
`default_nettype wire

// File: rtl/mem_timeout_cnt.sv
`default_nettype none
// ============================================================================
// Module      : mem_timeout_cnt
// Description : Per-transaction wait counter. Cleared when a transaction is
//               granted, advanced for every wait cycle without mem_rdy, and
//               flags expiry once it reaches TIMEOUT_CYC-1.
// Ports       : clk, rst_n  - clock, async active-low reset
//               clear       - zero the count (takes priority over enable)
//               enable      - advance the count by one
//               expired     - count has reached TIMEOUT_CYC-1
// Revision    : 1.0 - initial release
// ============================================================================
module mem_timeout_cnt
    import mem_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYC = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (enable) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign expired = (r_count == CNT_W'(TIMEOUT_CYC - 1));

endmodule : mem_timeout_cnt
`default_nettype wire

// File: rtl/mem_access_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_sequencer
// Description : Arbitrates instruction fetches and data loads/stores onto a
//               single memory bus, one transaction at a time, with a wait
//               timeout. All outputs are registered.
// Ports       : fetch_req/pc            - fetch request and address
//               data_req/op_code/SR1/SR2 - data request, opcode, addr, wdata
//               mem_rdy/mem_rdata       - memory completion and read data
//               mem_en/RW/add_bus/data_bus - memory bus
//               instr/instr_valid       - fetched word and strobe
//               data_reg/ld_valid       - loaded word and strobe
//               st_done                 - store-complete strobe
//               err                     - illegal opcode or timeout strobe
//               busy                    - transaction in progress
// Revision    : 1.0 - initial release
// ============================================================================
module mem_access_sequencer
    import mem_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYC = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fetch_req,
    input  logic [31:0] pc,
    input  logic        data_req,
    input  logic [3:0]  op_code,
    input  logic [31:0] SR1,
    input  logic [31:0] SR2,
    input  logic        mem_rdy,
    input  logic [31:0] mem_rdata,
    output logic        mem_en,
    output logic        RW,
    output logic [31:0] add_bus,
    output logic [31:0] data_bus,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic [31:0] data_reg,
    output logic        ld_valid,
    output logic        st_done,
    output logic        err,
    output logic        busy
);

    state_t      r_state, w_state_nxt;
    logic        r_last_was_data, w_last_was_data_nxt;
    logic        r_mem_en, w_mem_en_nxt;
    logic        r_rw, w_rw_nxt;
    logic [31:0] r_add_bus, w_add_bus_nxt;
    logic [31:0] r_data_bus, w_data_bus_nxt;
    logic [31:0] r_instr, w_instr_nxt;
    logic [31:0] r_data_reg, w_data_reg_nxt;
    logic        r_instr_valid, w_instr_valid_nxt;
    logic        r_ld_valid, w_ld_valid_nxt;
    logic        r_st_done, w_st_done_nxt;
    logic        r_err, w_err_nxt;
    logic        r_busy;

    logic        w_legal_data;
    logic        w_illegal_data;
    logic        w_cnt_clear;
    logic        w_cnt_en;
    logic        w_expired;

    mem_timeout_cnt #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timeout_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (w_cnt_clear),
        .enable  (w_cnt_en),
        .expired (w_expired)
    );

    assign w_legal_data   = data_req && is_legal_op(op_code);
    assign w_illegal_data = data_req && !is_legal_op(op_code);

    // ------------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state         <= IDLE;
            r_last_was_data <= 1'b0;
            r_mem_en        <= 1'b0;
            r_rw            <= RW_READ;
            r_add_bus       <= '0;
            r_data_bus      <= '0;
            r_instr         <= '0;
            r_data_reg      <= '0;
            r_instr_valid   <= 1'b0;
            r_ld_valid      <= 1'b0;
            r_st_done       <= 1'b0;
            r_err           <= 1'b0;
            r_busy          <= 1'b0;
        end else begin
            r_state         <= w_state_nxt;
            r_last_was_data <= w_last_was_data_nxt;
            r_mem_en        <= w_mem_en_nxt;
            r_rw            <= w_rw_nxt;
            r_add_bus       <= w_add_bus_nxt;
            r_data_bus      <= w_data_bus_nxt;
            r_instr         <= w_instr_nxt;
            r_data_reg      <= w_data_reg_nxt;
            r_instr_valid   <= w_instr_valid_nxt;
            r_ld_valid      <= w_ld_valid_nxt;
            r_st_done       <= w_st_done_nxt;
            r_err           <= w_err_nxt;
            r_busy          <= (w_state_nxt != IDLE);
        end
    end

    // ------------------------------------------------------------------------
    // Next-state and next-output logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt         = r_state;
        w_last_was_data_nxt = r_last_was_data;
        w_mem_en_nxt        = r_mem_en;
        w_rw_nxt            = r_rw;
        w_add_bus_nxt       = r_add_bus;
        w_data_bus_nxt      = r_data_bus;
        w_instr_nxt         = r_instr;
        w_data_reg_nxt      = r_data_reg;
        w_instr_valid_nxt   = 1'b0;
        w_ld_valid_nxt      = 1'b0;
        w_st_done_nxt       = 1'b0;
        w_err_nxt           = 1'b0;
        w_cnt_clear         = 1'b0;
        w_cnt_en            = 1'b0;

        case (r_state)
            IDLE: begin
                // Data normally wins; a pending fetch takes its turn only
                // right after a data grant, so neither side can starve.
                if (w_legal_data && !(fetch_req && r_last_was_data)) begin
                    w_state_nxt         = (op_code == OP_LDR) ? LOAD_WAIT : STORE_WAIT;
                    w_rw_nxt            = (op_code == OP_LDR) ? RW_READ : RW_WRITE;
                    w_add_bus_nxt       = SR1;
                    w_data_bus_nxt      = SR2;
                    w_mem_en_nxt        = 1'b1;
                    w_last_was_data_nxt = 1'b1;
                    w_cnt_clear         = 1'b1;
                end else if (fetch_req) begin
                    w_state_nxt         = FETCH_WAIT;
                    w_rw_nxt            = RW_READ;
                    w_add_bus_nxt       = pc;
                    w_data_bus_nxt      = SR2;
                    w_mem_en_nxt        = 1'b1;
                    w_last_was_data_nxt = 1'b0;
                    w_cnt_clear         = 1'b1;
                end
                // An illegal data request never blocks a fetch in the same cycle
                if (w_illegal_data) begin
                    w_err_nxt = 1'b1;
                end
            end

            FETCH_WAIT, LOAD_WAIT, STORE_WAIT: begin
                // mem_rdy has priority, so a response on the expiry cycle
                // still completes normally.
                if (mem_rdy) begin
                    w_state_nxt  = IDLE;
                    w_mem_en_nxt = 1'b0;
                    if (r_state == FETCH_WAIT) begin
                        w_instr_nxt       = mem_rdata;
                        w_instr_valid_nxt = 1'b1;
                    end else if (r_state == LOAD_WAIT) begin
                        w_data_reg_nxt = mem_rdata;
                        w_ld_valid_nxt = 1'b1;
                    end else begin
                        w_st_done_nxt = 1'b1;
                    end
                end else if (w_expired) begin
                    w_state_nxt  = IDLE;
                    w_mem_en_nxt = 1'b0;
                    w_err_nxt    = 1'b1;
                end else begin
                    w_cnt_en = 1'b1;
                end
            end

            default: begin
                w_state_nxt  = IDLE;
                w_mem_en_nxt = 1'b0;
            end
        endcase
    end

    assign mem_en      = r_mem_en;
    assign RW          = r_rw;
    assign add_bus     = r_add_bus;
    assign data_bus    = r_data_bus;
    assign instr       = r_instr;
    assign instr_valid = r_instr_valid;
    assign data_reg    = r_data_reg;
    assign ld_valid    = r_ld_valid;
    assign st_done     = r_st_done;
    assign err         = r_err;
    assign busy        = r_busy;

endmodule : mem_access_sequencer
`default_nettype wire

// File: tb/tb_mem_access_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_access_sequencer
// Description : Scoreboard bench for mem_access_sequencer. Stimulus pushes the
//               expected bus grants and completion strobes into queues; a
//               monitor on the falling edge pops and compares them whenever
//               the DUT starts a bus transaction or raises a strobe.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_access_sequencer;

    localparam int TIMEOUT_CYC = 4;

    localparam logic [1:0] K_INSTR = 2'd0;
    localparam logic [1:0] K_LD    = 2'd1;
    localparam logic [1:0] K_ST    = 2'd2;
    localparam logic [1:0] K_ERR   = 2'd3;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        rw;
    } grant_t;

    typedef struct {
        logic [1:0]  kind;
        logic [31:0] val;
    } done_t;

    logic        clk;
    logic        rst_n;
    logic        fetch_req;
    logic [31:0] pc;
    logic        data_req;
    logic [3:0]  op_code;
    logic [31:0] SR1;
    logic [31:0] SR2;
    logic        mem_rdy;
    logic [31:0] mem_rdata;
    logic        mem_en;
    logic        RW;
    logic [31:0] add_bus;
    logic [31:0] data_bus;
    logic [31:0] instr;
    logic        instr_valid;
    logic [31:0] data_reg;
    logic        ld_valid;
    logic        st_done;
    logic        err;
    logic        busy;

    int unsigned total = 0;
    int unsigned bad   = 0;

    grant_t gq[$];
    done_t  dq[$];

    mem_access_sequencer #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .fetch_req   (fetch_req),
        .pc          (pc),
        .data_req    (data_req),
        .op_code     (op_code),
        .SR1         (SR1),
        .SR2         (SR2),
        .mem_rdy     (mem_rdy),
        .mem_rdata   (mem_rdata),
        .mem_en      (mem_en),
        .RW          (RW),
        .add_bus     (add_bus),
        .data_bus    (data_bus),
        .instr       (instr),
        .instr_valid (instr_valid),
        .data_reg    (data_reg),
        .ld_valid    (ld_valid),
        .st_done     (st_done),
        .err         (err),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic flag(input string name);
        total++;
        bad++;
        $display("FAIL %s: actual=event required=none", name);
    endtask

    task automatic push_grant(input logic [31:0] a, input logic [31:0] d, input logic rw);
        grant_t g;
        g.addr = a; g.wdata = d; g.rw = rw;
        gq.push_back(g);
    endtask

    task automatic push_done(input logic [1:0] k, input logic [31:0] v);
        done_t e;
        e.kind = k; e.val = v;
        dq.push_back(e);
    endtask

    task automatic pop_done(input logic [1:0] k, input logic [31:0] v);
        done_t e;
        if (dq.size() == 0) begin
            flag($sformatf("unexpected_strobe_kind%0d", k));
        end else begin
            e = dq.pop_front();
            chk("strobe_kind", {30'd0, k}, {30'd0, e.kind});
            if (e.kind == K_INSTR || e.kind == K_LD)
                chk("strobe_data", v, e.val);
        end
    endtask

    // ------------------------------------------------------------------------
    // Monitor: grants, held bus values and completion strobes
    // ------------------------------------------------------------------------
    logic   prev_en = 1'b0;
    grant_t cur;

    always @(negedge clk) begin
        if (rst_n) begin
            if (mem_en) begin
                if (!prev_en) begin
                    if (gq.size() == 0) begin
                        flag("unexpected_grant");
                        cur.addr = add_bus; cur.wdata = data_bus; cur.rw = RW;
                    end else begin
                        cur = gq.pop_front();
                        chk("grant_addr", add_bus, cur.addr);
                        chk("grant_rw", {31'd0, RW}, {31'd0, cur.rw});
                        if (!cur.rw) chk("grant_wdata", data_bus, cur.wdata);
                    end
                end else begin
                    chk("hold_addr", add_bus, cur.addr);
                    chk("hold_rw", {31'd0, RW}, {31'd0, cur.rw});
                    if (!cur.rw) chk("hold_wdata", data_bus, cur.wdata);
                end
                chk("busy_in_wait", {31'd0, busy}, 32'd1);
            end
            if (instr_valid) pop_done(K_INSTR, instr);
            if (ld_valid)    pop_done(K_LD, data_reg);
            if (st_done)     pop_done(K_ST, 32'd0);
            if (err)         pop_done(K_ERR, 32'd0);
        end
        prev_en = mem_en;
    end

    // ------------------------------------------------------------------------
    // Memory responder: waits for the grant, holds mem_rdy low n_wait cycles,
    // then completes; optionally disturbs pc/SR1/SR2 during the wait and
    // drops requests in the strobe cycle.
    // ------------------------------------------------------------------------
    task automatic serve(input int n_wait, input logic [31:0] rdata,
                         input logic drop_f, input logic drop_d, input logic wiggle);
        int t = 0;
        logic [31:0] s_pc, s_sr1, s_sr2;
        while (!mem_en && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (!mem_en) begin
            flag("grant_wait_expired");
            return;
        end
        s_pc = pc; s_sr1 = SR1; s_sr2 = SR2;
        for (int i = 0; i < n_wait; i++) begin
            if (wiggle) begin
                pc  = pc  ^ 32'hA5A5_0000;
                SR1 = SR1 ^ 32'h0F0F_F0F0;
                SR2 = SR2 ^ 32'hFFFF_FFFF;
            end
            @(negedge clk);
        end
        pc = s_pc; SR1 = s_sr1; SR2 = s_sr2;
        mem_rdata = rdata;
        mem_rdy   = 1'b1;
        @(negedge clk);
        mem_rdy = 1'b0;
        if (drop_f) fetch_req = 1'b0;
        if (drop_d) data_req  = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    // ------------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------------
    initial begin
        int n_en;
        rst_n = 1'b0; fetch_req = 1'b0; data_req = 1'b0; op_code = 4'h0;
        pc = '0; SR1 = '0; SR2 = '0; mem_rdy = 1'b0; mem_rdata = '0;
        idle_cycles(3);

        // Reset state
        chk("rst_mem_en", {31'd0, mem_en}, 32'd0);
        chk("rst_rw", {31'd0, RW}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_add_bus", add_bus, 32'd0);
        chk("rst_instr", instr, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        rst_n = 1'b1;
        idle_cycles(2);

        // Lone fetch, response on the 4th wait cycle (the expiry cycle)
        pc = 32'h0000_0100; fetch_req = 1'b1;
        push_grant(32'h0000_0100, 32'h0, 1'b1);
        push_done(K_INSTR, 32'hDEAD_BEEF);
        serve(3, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b1);
        idle_cycles(3);
        chk("fetch_instr_hold", instr, 32'hDEAD_BEEF);
        chk("fetch_idle_busy", {31'd0, busy}, 32'd0);

        // Simultaneous fetch + STR: store first, then fetch
        pc = 32'h0000_0300; fetch_req = 1'b1;
        op_code = 4'b1110; SR1 = 32'h0000_0040; SR2 = 32'h0000_1234; data_req = 1'b1;
        push_grant(32'h0000_0040, 32'h0000_1234, 1'b0);
        push_done(K_ST, 32'h0);
        push_grant(32'h0000_0300, 32'h0, 1'b1);
        push_done(K_INSTR, 32'h1111_2222);
        serve(2, 32'h0, 1'b0, 1'b1, 1'b1);
        serve(1, 32'h1111_2222, 1'b1, 1'b0, 1'b0);
        idle_cycles(3);

        // Fairness: continuous LDR and fetch alternate data/fetch/data/fetch
        op_code = 4'b1101; SR1 = 32'h0000_0080; pc = 32'h0000_0200;
        data_req = 1'b1; fetch_req = 1'b1;
        push_grant(32'h0000_0080, 32'h0, 1'b1); push_done(K_LD,    32'hAAAA_0001);
        push_grant(32'h0000_0200, 32'h0, 1'b1); push_done(K_INSTR, 32'hBBBB_0002);
        push_grant(32'h0000_0080, 32'h0, 1'b1); push_done(K_LD,    32'hCCCC_0003);
        push_grant(32'h0000_0200, 32'h0, 1'b1); push_done(K_INSTR, 32'hDDDD_0004);
        serve(0, 32'hAAAA_0001, 1'b0, 1'b0, 1'b0);
        serve(1, 32'hBBBB_0002, 1'b0, 1'b0, 1'b0);
        serve(0, 32'hCCCC_0003, 1'b0, 1'b0, 1'b0);
        serve(2, 32'hDDDD_0004, 1'b1, 1'b1, 1'b0);
        idle_cycles(3);
        chk("fair_data_reg", data_reg, 32'hCCCC_0003);

        // Illegal opcode alone: one err, no bus access
        op_code = 4'b0011; SR1 = 32'h0000_0999; data_req = 1'b1;
        push_done(K_ERR, 32'h0);
        @(negedge clk);
        data_req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("illegal_mem_en", {31'd0, mem_en}, 32'd0);
            @(negedge clk);
        end

        // Illegal opcode with fetch: err and fetch grant from the same edge
        op_code = 4'b0000; data_req = 1'b1; pc = 32'h0000_0400; fetch_req = 1'b1;
        push_done(K_ERR, 32'h0);
        push_grant(32'h0000_0400, 32'h0, 1'b1);
        push_done(K_INSTR, 32'h4444_5555);
        @(negedge clk);
        chk("illegal_fetch_err", {31'd0, err}, 32'd1);
        data_req = 1'b0;
        serve(0, 32'h4444_5555, 1'b1, 1'b0, 1'b0);
        idle_cycles(2);

        // Timeout: LDR with mem_rdy held low
        op_code = 4'b1101; SR1 = 32'h0000_0500; data_req = 1'b1;
        push_grant(32'h0000_0500, 32'h0, 1'b1);
        push_done(K_ERR, 32'h0);
        n_en = 0;
        for (int i = 0; i < 20 && !err; i++) begin
            @(negedge clk);
            if (mem_en) n_en++;
        end
        chk("timeout_err_seen", {31'd0, err}, 32'd1);
        chk("timeout_wait_cycles", n_en, TIMEOUT_CYC);
        chk("timeout_idle", {31'd0, busy}, 32'd0);
        data_req = 1'b0;
        idle_cycles(3);

        // Reset in the middle of an LDR
        op_code = 4'b1101; SR1 = 32'h0000_0600; SR2 = 32'h0000_7777; data_req = 1'b1;
        push_grant(32'h0000_0600, 32'h0, 1'b1);
        n_en = 0;
        while (!mem_en && n_en < 20) begin
            @(negedge clk);
            n_en++;
        end
        chk("rstmid_granted", {31'd0, mem_en}, 32'd1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rstmid_mem_en", {31'd0, mem_en}, 32'd0);
        chk("rstmid_rw", {31'd0, RW}, 32'd1);
        chk("rstmid_busy", {31'd0, busy}, 32'd0);
        chk("rstmid_add_bus", add_bus, 32'd0);
        chk("rstmid_data_bus", data_bus, 32'd0);
        chk("rstmid_instr", instr, 32'd0);
        chk("rstmid_data_reg", data_reg, 32'd0);
        chk("rstmid_ld_valid", {31'd0, ld_valid}, 32'd0);
        data_req = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        mem_rdata = 32'hBAD0_BAD0; mem_rdy = 1'b1;
        @(negedge clk);
        mem_rdy = 1'b0;
        idle_cycles(4);
        chk("rstmid_after_busy", {31'd0, busy}, 32'd0);

        // Every expected event must have been consumed
        chk("grant_queue_empty", gq.size(), 32'd0);
        chk("done_queue_empty", dq.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: actual=running required=finished");
        $fatal(1, "watchdog");
    end

endmodule : tb_mem_access_sequencer
`default_nettype wire
